itype_exec_ctrl: RTL

- Multi-cycle sequencer for the combinational I-type ALU datapath (sign-extended 12-bit immediate, ADDI on funct3=000).
- Accepts one 32-bit instruction per transaction via valid/ready and reads rs1 from the register file.
- Presents operands to the ALU, captures the result, writes it back to rd, and signals completion.
- Sits between the instruction source and the register file and ALU; it owns the register-file read and write ports while busy.

---
 rtl/itype_pkg.sv | 25 ++
 rtl/itype_decode.sv | 21 ++
 rtl/itype_exec_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/itype_pkg.sv
// Shared encodings, field positions and controller state enum for the I-type
// ADDI execution path.
package itype_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI    = 3'b000;

  // Field LSB positions inside a 32-bit instruction word.
  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int F3_W    = 3;
  localparam int RS1_LSB = 15;
  localparam int REG_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } itype_state_e;

endpackage

// File: rtl/itype_decode.sv
// Field extraction and legality check for ADDI. Only the low 20 bits carry
// the fields this block needs; the immediate is the ALU's concern.
module itype_decode
  import itype_pkg::*;
(
  input  logic [19:0]      instr_lo_i,
  output logic [REG_W-1:0] rs1_o,
  output logic [REG_W-1:0] rd_o,
  output logic             legal_o
);

  logic [OPC_W-1:0] opcode;
  logic [F3_W-1:0]  funct3;

  assign opcode  = instr_lo_i[OPC_LSB +: OPC_W];
  assign funct3  = instr_lo_i[F3_LSB +: F3_W];
  assign rs1_o   = instr_lo_i[RS1_LSB +: REG_W];
  assign rd_o    = instr_lo_i[RD_LSB +: REG_W];
  assign legal_o = (opcode == OPC_OP_IMM) && (funct3 == F3_ADDI);

endmodule

// File: rtl/itype_exec_ctrl.sv
// Multi-cycle sequencer: accept instruction, read rs1, feed the ALU, write rd.
// Handshake: an instruction is taken on a rising edge where instr_valid && instr_ready.
module itype_exec_ctrl
  import itype_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic             rf_ren,
  output logic [AW-1:0]    rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [XLEN-1:0]  alu_rs1,
  output logic [31:0]      alu_instr,
  input  logic [XLEN-1:0]  alu_result,
  output logic             done,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output itype_state_e     dbg_state
);

  itype_state_e     state_q, state_d;
  logic [31:0]      alu_instr_q, alu_instr_d;
  logic [XLEN-1:0]  alu_rs1_q, alu_rs1_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [19:0]      dec_src;
  logic [REG_W-1:0] dec_rs1, dec_rd;
  logic             dec_legal;

  // In IDLE decode the incoming word for the legality decision; otherwise
  // decode the latched copy that drives the ALU.
  assign dec_src = (state_q == ST_IDLE) ? instr[19:0] : alu_instr_q[19:0];

  itype_decode u_decode (
    .instr_lo_i (dec_src),
    .rs1_o      (dec_rs1),
    .rd_o       (dec_rd),
    .legal_o    (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) state_d = dec_legal ? ST_READ : ST_ERR;
        else             state_d = ST_IDLE;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    rf_ren      = 1'b0;
    rf_raddr    = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_READ: begin
        rf_ren   = 1'b1;
        rf_raddr = AW'(dec_rs1);
      end
      ST_WB: begin
        done     = 1'b1;
        rf_waddr = AW'(dec_rd);
        rf_wdata = alu_result;
        rf_we    = (dec_rd != '0);
      end
      ST_ERR: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_instr_d = alu_instr_q;
    alu_rs1_d   = alu_rs1_q;
    retired_d   = retired_q;
    if (state_q == ST_IDLE && instr_valid) alu_instr_d = instr;
    // x0 reads as zero whatever the register file returns.
    if (state_q == ST_EXEC) alu_rs1_d = (dec_rs1 == '0) ? '0 : rf_rdata;
    if (state_q == ST_WB)   retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_instr_q <= '0;
      alu_rs1_q   <= '0;
      retired_q   <= '0;
    end else begin
      alu_instr_q <= alu_instr_d;
      alu_rs1_q   <= alu_rs1_d;
      retired_q   <= retired_d;
    end
  end

  assign alu_instr = alu_instr_q;
  assign alu_rs1   = alu_rs1_q;
  assign retired   = retired_q;
  assign dbg_state = state_q;

endmodule
